// File: rtl/u_idu_pkg.sv
// Shared types for the instruction decode stage.
//  op_e      : decoded operation class presented to execute
//  imm_fmt_e : immediate encoding format selected by the decoder
//  idu_st_e  : replay state (RUN accepting fetch, WAIT for refetched pc)
//  fetch_t   : {pc, ins} payload stored per FIFO entry
package u_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned FIFO_W = 2 * XLEN;

    typedef enum logic [3:0] {
        OP_LUI    = 4'd0,
        OP_AUIPC  = 4'd1,
        OP_JAL    = 4'd2,
        OP_JALR   = 4'd3,
        OP_BRANCH = 4'd4,
        OP_LOAD   = 4'd5,
        OP_STORE  = 4'd6,
        OP_OPIMM  = 4'd7,
        OP_OP     = 4'd8,
        OP_FENCE  = 4'd9,
        OP_SYSTEM = 4'd10,
        OP_ILL    = 4'd11
    } op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_fmt_e;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } idu_st_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } fetch_t;

endpackage

// File: rtl/u_idu_fifo.sv
// Synchronous FIFO holding fetched words ahead of decode.
//  clk, rstn : clock, async active-low reset
//  clr       : synchronous empty (wins over push/pop)
//  push/wdata: write one entry
//  pop       : drop head entry
//  head_c    : current head entry (combinational)
//  full_c    : all DEPTH entries occupied
//  empty_c   : no entries
module u_idu_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head_c,
    output logic         full_c,
    output logic         empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [W-1:0]  mem [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
        end
    end

    // Storage; a push into the slot being popped on a full FIFO is safe since head is read pre-edge.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wptr[AW-1:0]] <= wdata;
    end

    assign head_c  = mem[rptr[AW-1:0]];
    assign full_c  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty_c = (wptr == rptr);

endmodule

// File: rtl/u_idu.sv
// Instruction decode stage: buffers fetch words, decodes RV32I fields and
// immediates, and holds them in a valid/ready output register for execute.
// Fetch cannot stall, so an overflowing word is dropped and a refetch requested.
//  clk, rstn         : clock, async active-low reset
//  flush             : pipeline flush, empties everything
//  ifu_vld/pc/ins    : fetch word
//  idu_vld/idu_rdy   : output handshake to execute
//  idu_pc..idu_ill   : registered decoded fields
//  rpl_req/rpl_adr   : one-cycle refetch request and its pc
module u_idu
    import u_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        ifu_vld,
    input  logic [31:0] ifu_pc,
    input  logic [31:0] ifu_ins,
    output logic        idu_vld,
    input  logic        idu_rdy,
    output logic [31:0] idu_pc,
    output logic [31:0] idu_ins,
    output logic [3:0]  idu_op,
    output logic [4:0]  idu_rd,
    output logic [4:0]  idu_rs1,
    output logic [4:0]  idu_rs2,
    output logic [2:0]  idu_f3,
    output logic [6:0]  idu_f7,
    output logic [31:0] idu_imm,
    output logic        idu_ill,
    output logic        rpl_req,
    output logic [31:0] rpl_adr
);

    idu_st_e            st_q;
    idu_st_e            st_nxt;
    logic               rpl_pend_q;
    logic               rpl_pend_nxt;
    logic               rpl_req_nxt;
    logic [31:0]        rpl_adr_nxt;

    fetch_t             wdata_c;
    logic [FIFO_W-1:0]  head_raw_c;
    fetch_t             head_c;
    logic               full_c;
    logic               empty_c;
    logic               load_c;
    logic               pop_c;
    logic               cand_c;
    logic               push_c;
    logic               ovf_c;

    op_e                op_c;
    imm_fmt_e           fmt_c;
    logic               ill_c;
    logic [31:0]        imm_c;

    assign wdata_c = '{pc: ifu_pc, ins: ifu_ins};
    assign head_c  = fetch_t'(head_raw_c);

    u_idu_fifo #(
        .DEPTH (DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (flush),
        .push    (push_c),
        .wdata   (FIFO_W'(wdata_c)),
        .pop     (pop_c),
        .head_c  (head_raw_c),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // Handshake: in WAIT only the refetched pc is a push candidate.
    always_comb begin
        load_c = !idu_vld || idu_rdy;
        pop_c  = !empty_c && load_c && !flush;
        cand_c = ifu_vld && !flush && ((st_q == RUN) || (ifu_pc == rpl_adr));
        push_c = cand_c && (!full_c || pop_c);
        ovf_c  = cand_c && full_c && !pop_c;
    end

    // Replay FSM next state; a re-issue that collides with a live request is deferred one cycle.
    always_comb begin
        st_nxt       = st_q;
        rpl_req_nxt  = 1'b0;
        rpl_pend_nxt = rpl_pend_q;
        rpl_adr_nxt  = rpl_adr;
        if (flush) begin
            st_nxt       = RUN;
            rpl_pend_nxt = 1'b0;
        end else begin
            case (st_q)
                RUN: begin
                    if (ovf_c) begin
                        st_nxt       = WAIT;
                        rpl_adr_nxt  = ifu_pc;
                        rpl_req_nxt  = 1'b1;
                        rpl_pend_nxt = 1'b0;
                    end
                end
                WAIT: begin
                    if (push_c) begin
                        st_nxt       = RUN;
                        rpl_pend_nxt = 1'b0;
                    end else if (ovf_c || rpl_pend_q) begin
                        rpl_req_nxt  = !rpl_req;
                        rpl_pend_nxt = rpl_req;
                    end
                end
                default: st_nxt = RUN;
            endcase
        end
    end

    // Replay FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q       <= RUN;
            rpl_pend_q <= 1'b0;
            rpl_req    <= 1'b0;
            rpl_adr    <= '0;
        end else begin
            st_q       <= st_nxt;
            rpl_pend_q <= rpl_pend_nxt;
            rpl_req    <= rpl_req_nxt;
            rpl_adr    <= rpl_adr_nxt;
        end
    end

    // Decoder on the FIFO head.
    always_comb begin
        op_c  = OP_ILL;
        fmt_c = IMM_NONE;
        imm_c = '0;
        if (head_c.ins[1:0] == 2'b11) begin
            case (head_c.ins[6:0])
                OPC_LUI:    begin op_c = OP_LUI;    fmt_c = IMM_U;    end
                OPC_AUIPC:  begin op_c = OP_AUIPC;  fmt_c = IMM_U;    end
                OPC_JAL:    begin op_c = OP_JAL;    fmt_c = IMM_J;    end
                OPC_JALR:   begin op_c = OP_JALR;   fmt_c = IMM_I;    end
                OPC_BRANCH: begin op_c = OP_BRANCH; fmt_c = IMM_B;    end
                OPC_LOAD:   begin op_c = OP_LOAD;   fmt_c = IMM_I;    end
                OPC_STORE:  begin op_c = OP_STORE;  fmt_c = IMM_S;    end
                OPC_OPIMM:  begin op_c = OP_OPIMM;  fmt_c = IMM_I;    end
                OPC_OP:     begin op_c = OP_OP;     fmt_c = IMM_NONE; end
                OPC_FENCE:  begin op_c = OP_FENCE;  fmt_c = IMM_I;    end
                OPC_SYSTEM: begin op_c = OP_SYSTEM; fmt_c = IMM_I;    end
                default:    begin op_c = OP_ILL;    fmt_c = IMM_NONE; end
            endcase
        end
        ill_c = (op_c == OP_ILL);
        case (fmt_c)
            IMM_I: imm_c = {{20{head_c.ins[31]}}, head_c.ins[31:20]};
            IMM_S: imm_c = {{20{head_c.ins[31]}}, head_c.ins[31:25], head_c.ins[11:7]};
            IMM_B: imm_c = {{19{head_c.ins[31]}}, head_c.ins[31], head_c.ins[7],
                            head_c.ins[30:25], head_c.ins[11:8], 1'b0};
            IMM_U: imm_c = {head_c.ins[31:12], 12'b0};
            IMM_J: imm_c = {{11{head_c.ins[31]}}, head_c.ins[31], head_c.ins[19:12],
                            head_c.ins[20], head_c.ins[30:21], 1'b0};
            default: imm_c = '0;
        endcase
    end

    // Output register; fields hold while execute is not ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idu_vld <= 1'b0;
            idu_pc  <= '0;
            idu_ins <= '0;
            idu_op  <= '0;
            idu_rd  <= '0;
            idu_rs1 <= '0;
            idu_rs2 <= '0;
            idu_f3  <= '0;
            idu_f7  <= '0;
            idu_imm <= '0;
            idu_ill <= 1'b0;
        end else if (flush) begin
            idu_vld <= 1'b0;
            idu_pc  <= '0;
            idu_ins <= '0;
            idu_op  <= '0;
            idu_rd  <= '0;
            idu_rs1 <= '0;
            idu_rs2 <= '0;
            idu_f3  <= '0;
            idu_f7  <= '0;
            idu_imm <= '0;
            idu_ill <= 1'b0;
        end else if (load_c) begin
            idu_vld <= pop_c;
            if (pop_c) begin
                idu_pc  <= head_c.pc;
                idu_ins <= head_c.ins;
                idu_op  <= op_c;
                idu_rd  <= head_c.ins[11:7];
                idu_rs1 <= head_c.ins[19:15];
                idu_rs2 <= head_c.ins[24:20];
                idu_f3  <= head_c.ins[14:12];
                idu_f7  <= head_c.ins[31:25];
                idu_imm <= imm_c;
                idu_ill <= ill_c;
            end
        end
    end

endmodule

// File: tb/tb_u_idu.sv
// Directed bench for the decode stage: latency/order, decode, overflow replay,
// flush, full-FIFO push+pop, illegal encodings and async reset.
module tb_u_idu;
    import u_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        ifu_vld;
    logic [31:0] ifu_pc;
    logic [31:0] ifu_ins;
    logic        idu_vld;
    logic        idu_rdy;
    logic [31:0] idu_pc;
    logic [31:0] idu_ins;
    logic [3:0]  idu_op;
    logic [4:0]  idu_rd;
    logic [4:0]  idu_rs1;
    logic [4:0]  idu_rs2;
    logic [2:0]  idu_f3;
    logic [6:0]  idu_f7;
    logic [31:0] idu_imm;
    logic        idu_ill;
    logic        rpl_req;
    logic [31:0] rpl_adr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    u_idu #(.DEPTH(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .ifu_vld (ifu_vld),
        .ifu_pc  (ifu_pc),
        .ifu_ins (ifu_ins),
        .idu_vld (idu_vld),
        .idu_rdy (idu_rdy),
        .idu_pc  (idu_pc),
        .idu_ins (idu_ins),
        .idu_op  (idu_op),
        .idu_rd  (idu_rd),
        .idu_rs1 (idu_rs1),
        .idu_rs2 (idu_rs2),
        .idu_f3  (idu_f3),
        .idu_f7  (idu_f7),
        .idu_imm (idu_imm),
        .idu_ill (idu_ill),
        .rpl_req (rpl_req),
        .rpl_adr (rpl_adr)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [159:0] all_out();
        return {idu_vld, idu_pc, idu_ins, idu_op, idu_rd, idu_rs1, idu_rs2,
                idu_f3, idu_f7, idu_imm, idu_ill, rpl_req, rpl_adr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        ifu_vld = v;
        ifu_pc  = pc;
        ifu_ins = ins;
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 32'h0);
        idu_rdy = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        flush = 1'b0;
        idu_rdy = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #12;
        checks++;
        if (all_out() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", all_out());
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_straight();
        logic        exp_v;
        logic [31:0] exp_pc;
        idu_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) drive(1'b1, 32'(c * 4), NOP);
            else       drive(1'b0, 32'h0, 32'h0);
            tick();
            exp_v  = (c >= 1) && (c <= 8);
            exp_pc = 32'((c - 1) * 4);
            checks++;
            if (idu_vld !== exp_v || (exp_v && idu_pc !== exp_pc)) begin
                errors++;
                $display("FAIL straight c=%0d vld=%b pc=%h exp vld=%b pc=%h",
                         c, idu_vld, idu_pc, exp_v, exp_pc);
            end
        end
    endtask

    task automatic test_decode();
        idu_rdy = 1'b1;
        drive(1'b1, 32'h100, 32'h0050_0093);
        tick();
        drive(1'b1, 32'h104, 32'hFE00_0EE3);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if (idu_vld !== 1'b1 || idu_pc !== 32'h100 || idu_op !== 4'(OP_OPIMM) ||
            idu_rd !== 5'd1 || idu_rs1 !== 5'd0 || idu_f3 !== 3'd0 ||
            idu_imm !== 32'd5 || idu_ill !== 1'b0) begin
            errors++;
            $display("FAIL decode_addi vld=%b pc=%h op=%0d rd=%0d rs1=%0d f3=%0d imm=%h ill=%b exp 1 100 %0d 1 0 0 5 0",
                     idu_vld, idu_pc, idu_op, idu_rd, idu_rs1, idu_f3, idu_imm, idu_ill, OP_OPIMM);
        end
        tick();
        checks++;
        if (idu_vld !== 1'b1 || idu_pc !== 32'h104 || idu_op !== 4'(OP_BRANCH) ||
            idu_imm !== 32'hFFFF_FFFC || idu_f7 !== 7'h7F || idu_rs2 !== 5'd0 ||
            idu_ill !== 1'b0) begin
            errors++;
            $display("FAIL decode_branch vld=%b pc=%h op=%0d imm=%h f7=%h rs2=%0d ill=%b exp 1 104 %0d fffffffc 7f 0 0",
                     idu_vld, idu_pc, idu_op, idu_imm, idu_f7, idu_rs2, idu_ill, OP_BRANCH);
        end
        tick();
        checks++;
        if (idu_vld !== 1'b0) begin
            errors++;
            $display("FAIL decode_drain vld=%b exp 0", idu_vld);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pc [6];
        exp_pc = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54};
        idu_rdy = 1'b0;
        drive(1'b1, 32'h3C, NOP);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(32'h40 + 4 * i), NOP);
            tick();
        end
        drive(1'b1, 32'h50, NOP);
        tick();
        checks++;
        if (rpl_req !== 1'b1 || rpl_adr !== 32'h50) begin
            errors++;
            $display("FAIL ovf_replay req=%b adr=%h exp 1 00000050", rpl_req, rpl_adr);
        end
        checks++;
        if (idu_vld !== 1'b1 || idu_pc !== 32'h3C) begin
            errors++;
            $display("FAIL ovf_hold vld=%b pc=%h exp 1 0000003c", idu_vld, idu_pc);
        end
        drive(1'b1, 32'h54, NOP);
        tick();
        checks++;
        if (rpl_req !== 1'b0) begin
            errors++;
            $display("FAIL ovf_req_pulse req=%b exp 0", rpl_req);
        end
        idu_rdy = 1'b1;
        drive(1'b1, 32'h50, NOP);
        tick();
        drive(1'b1, 32'h54, NOP);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (idu_vld !== 1'b1 || idu_pc !== exp_pc[k] || rpl_req !== 1'b0) begin
                errors++;
                $display("FAIL ovf_stream k=%0d vld=%b pc=%h req=%b exp 1 %h 0",
                         k, idu_vld, idu_pc, rpl_req, exp_pc[k]);
            end
            tick();
            drive(1'b0, 32'h0, 32'h0);
        end
        checks++;
        if (idu_vld !== 1'b0) begin
            errors++;
            $display("FAIL ovf_stream_end vld=%b pc=%h exp vld 0", idu_vld, idu_pc);
        end
    endtask

    task automatic test_flush();
        idu_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(32'h100 + 4 * i), NOP);
            tick();
        end
        drive(1'b1, 32'h114, NOP);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        idu_rdy = 1'b1;
        tick();
        checks++;
        if (idu_vld !== 1'b1 || idu_pc !== 32'h104 || rpl_req !== 1'b0 || rpl_adr !== 32'h114) begin
            errors++;
            $display("FAIL flush_setup vld=%b pc=%h req=%b adr=%h exp 1 00000104 0 00000114",
                     idu_vld, idu_pc, rpl_req, rpl_adr);
        end
        flush = 1'b1;
        idu_rdy = 1'b0;
        drive(1'b1, 32'h114, NOP);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if (idu_vld !== 1'b0 || rpl_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear vld=%b req=%b exp 0 0", idu_vld, rpl_req);
        end
        tick();
        checks++;
        if (idu_vld !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty vld=%b pc=%h exp vld 0", idu_vld, idu_pc);
        end
        drive(1'b1, 32'h200, NOP);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        tick();
        checks++;
        if (idu_vld !== 1'b1 || idu_pc !== 32'h200) begin
            errors++;
            $display("FAIL flush_run vld=%b pc=%h exp 1 00000200", idu_vld, idu_pc);
        end
        drain();
    endtask

    task automatic test_full_pushpop();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h308, 32'h30C, 32'h310, 32'h314};
        idu_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(32'h300 + 4 * i), NOP);
            tick();
        end
        idu_rdy = 1'b1;
        drive(1'b1, 32'h314, NOP);
        tick();
        checks++;
        if (rpl_req !== 1'b0 || idu_vld !== 1'b1 || idu_pc !== 32'h304) begin
            errors++;
            $display("FAIL full_pushpop req=%b vld=%b pc=%h exp 0 1 00000304", rpl_req, idu_vld, idu_pc);
        end
        idu_rdy = 1'b0;
        drive(1'b1, 32'h318, NOP);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if (rpl_req !== 1'b1 || rpl_adr !== 32'h318) begin
            errors++;
            $display("FAIL full_count req=%b adr=%h exp 1 00000318", rpl_req, rpl_adr);
        end
        idu_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (idu_vld !== 1'b1 || idu_pc !== exp_pc[k]) begin
                errors++;
                $display("FAIL full_drain k=%0d vld=%b pc=%h exp 1 %h", k, idu_vld, idu_pc, exp_pc[k]);
            end
        end
        tick();
        checks++;
        if (idu_vld !== 1'b0) begin
            errors++;
            $display("FAIL full_drain_end vld=%b exp 0", idu_vld);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_illegal();
        idu_rdy = 1'b1;
        drive(1'b1, 32'h400, 32'h0000_0000);
        tick();
        drive(1'b1, 32'h404, 32'h0000_007F);
        tick();
        drive(1'b1, 32'h408, 32'h0050_0093);
        checks++;
        if (idu_vld !== 1'b1 || idu_pc !== 32'h400 || idu_ill !== 1'b1 ||
            idu_op !== 4'(OP_ILL) || idu_imm !== 32'h0) begin
            errors++;
            $display("FAIL illegal_zero vld=%b pc=%h ill=%b op=%0d imm=%h exp 1 00000400 1 %0d 0",
                     idu_vld, idu_pc, idu_ill, idu_op, idu_imm, OP_ILL);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if (idu_vld !== 1'b1 || idu_pc !== 32'h404 || idu_ill !== 1'b1 || idu_op !== 4'(OP_ILL)) begin
            errors++;
            $display("FAIL illegal_opc vld=%b pc=%h ill=%b op=%0d exp 1 00000404 1 %0d",
                     idu_vld, idu_pc, idu_ill, idu_op, OP_ILL);
        end
        tick();
        checks++;
        if (idu_vld !== 1'b1 || idu_pc !== 32'h408 || idu_ill !== 1'b0 || idu_op !== 4'(OP_OPIMM)) begin
            errors++;
            $display("FAIL illegal_after vld=%b pc=%h ill=%b op=%0d exp 1 00000408 0 %0d",
                     idu_vld, idu_pc, idu_ill, idu_op, OP_OPIMM);
        end
        drain();
    endtask

    task automatic test_async_reset();
        idu_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(32'h500 + 4 * i), 32'h0010_00B7);
            tick();
        end
        checks++;
        if (idu_vld !== 1'b1 || idu_op !== 4'(OP_LUI) || idu_imm !== 32'h0010_0000) begin
            errors++;
            $display("FAIL areset_pre vld=%b op=%0d imm=%h exp 1 %0d 00100000",
                     idu_vld, idu_op, idu_imm, OP_LUI);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (all_out() !== '0) begin
            errors++;
            $display("FAIL areset_outputs got=%h exp=0", all_out());
        end
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        checks++;
        if (idu_vld !== 1'b0 || rpl_req !== 1'b0) begin
            errors++;
            $display("FAIL areset_empty vld=%b req=%b exp 0 0", idu_vld, rpl_req);
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_decode();
        test_overflow();
        test_flush();
        test_full_pushpop();
        test_illegal();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
